mult_div_unit: RTL and testbench

- Iterative multi-cycle multiply/divide unit that receives mult/div requests from the execute stage and produces the HI/LO register pair.
- Consumer side of the ALU's hi/lo path: the ALU issues the operands, this block computes over 34 cycles and holds HI/LO for mfhi/mflo reads.
- The pipeline stalls on `busy`.

---
 rtl/mult_div_unit_pkg.sv | 29 ++
 rtl/mult_div_unit_if.sv | 29 ++
 rtl/mult_div_unit_step.sv | 38 +++
 rtl/mult_div_unit.sv | 167 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes,
// FSM states and small decode helpers.
package mult_div_unit_pkg;

    localparam int MD_WIDTH_DEF = 32;
    localparam int MD_CNT_W_DEF = 6;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_RUN  = 2'b01,
        MD_FIX  = 2'b10
    } md_state_e;

    function automatic logic md_is_div(md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_signed(md_op_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the execute stage (master) and the
// multiply/divide unit (slave).
interface mult_div_unit_if
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH_DEF
);

    logic             start;
    md_op_e           md_op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, md_op, src_a, src_b,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, md_op, src_a, src_b,
        output busy, done, div_by_zero, hi, lo
    );

endinterface

// File: rtl/mult_div_unit_step.sv
// One combinational iteration: shift-add multiply or restoring divide on a
// shared {upper[WIDTH:0], lower[WIDTH-1:0]} accumulator.
module md_iter_step
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH_DEF
) (
    input  logic [2*WIDTH:0] acc_i,
    input  logic [WIDTH-1:0] opnd_i,
    input  md_op_e           op_i,
    output logic [2*WIDTH:0] acc_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;

    always_comb begin
        sum     = '0;
        shifted = '0;
        diff    = '0;
        acc_o   = acc_i;
        if (md_is_div(op_i)) begin
            // Remainder takes the next dividend bit; quotient bit enters at the LSB.
            shifted = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
            diff    = {1'b0, shifted} - {2'b00, opnd_i};
            if (diff[WIDTH+1]) begin
                acc_o = {shifted, acc_i[WIDTH-2:0], 1'b0};
            end else begin
                acc_o = {diff[WIDTH:0], acc_i[WIDTH-2:0], 1'b1};
            end
        end else begin
            sum   = acc_i[2*WIDTH:WIDTH] + (acc_i[0] ? {1'b0, opnd_i} : '0);
            acc_o = {1'b0, sum, acc_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: operands are converted to magnitudes, iterated
// WIDTH times, sign-corrected and committed to the HI/LO pair.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH_DEF,
    parameter int CNT_W = MD_CNT_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    mult_div_unit_if.slave md
);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    md_op_e           op_q, op_d;
    logic             neg_q, neg_d;
    logic             rneg_q, rneg_d;
    logic             bz_q, bz_d;
    logic             fix_ph_q, fix_ph_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [2*WIDTH:0] acc_q, acc_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic [WIDTH-1:0] res_lo_q, res_lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic [2*WIDTH:0]   acc_step;
    logic               sa, sb;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] prod_raw, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    md_iter_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .acc_i (acc_q),
        .opnd_i(opnd_q),
        .op_i  (op_q),
        .acc_o (acc_step)
    );

    always_comb begin
        sa    = md_is_signed(md.md_op) & md.src_a[WIDTH-1];
        sb    = md_is_signed(md.md_op) & md.src_b[WIDTH-1];
        mag_a = sa ? -md.src_a : md.src_a;
        mag_b = sb ? -md.src_b : md.src_b;
    end

    // A zero divisor leaves the dividend magnitude as remainder, so only LO needs forcing.
    always_comb begin
        prod_raw = acc_q[2*WIDTH-1:0];
        prod_fix = neg_q ? -prod_raw : prod_raw;
        quo_fix  = bz_q ? '1 : (neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
        rem_fix  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        if (md_is_div(op_q)) begin
            fix_hi = rem_fix;
            fix_lo = quo_fix;
        end else begin
            fix_hi = prod_fix[2*WIDTH-1:WIDTH];
            fix_lo = prod_fix[WIDTH-1:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        bz_d     = bz_q;
        fix_ph_d = fix_ph_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dbz_d    = dbz_q;
        unique case (state_q)
            MD_IDLE: begin
                if (md.start) begin
                    op_d    = md.md_op;
                    neg_d   = sa ^ sb;
                    rneg_d  = sa;
                    bz_d    = md_is_div(md.md_op) && (md.src_b == '0);
                    opnd_d  = md_is_div(md.md_op) ? mag_b : mag_a;
                    acc_d   = {{(WIDTH+1){1'b0}}, (md_is_div(md.md_op) ? mag_a : mag_b)};
                    cnt_d   = '0;
                    dbz_d   = 1'b0;
                    state_d = MD_RUN;
                end
            end
            MD_RUN: begin
                acc_d = acc_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH-1)) begin
                    fix_ph_d = 1'b0;
                    state_d  = MD_FIX;
                end
            end
            MD_FIX: begin
                // Sign correction is registered first, then committed, keeping the
                // negate off the HI/LO write path.
                if (!fix_ph_q) begin
                    res_hi_d = fix_hi;
                    res_lo_d = fix_lo;
                    fix_ph_d = 1'b1;
                end else begin
                    hi_d    = res_hi_q;
                    lo_d    = res_lo_q;
                    done_d  = 1'b1;
                    dbz_d   = bz_q;
                    state_d = MD_IDLE;
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= MD_IDLE;
            cnt_q    <= '0;
            op_q     <= MD_MULT;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            bz_q     <= 1'b0;
            fix_ph_q <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            bz_q     <= bz_d;
            fix_ph_q <= fix_ph_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign md.busy        = (state_q != MD_IDLE);
    assign md.done        = done_q;
    assign md.div_by_zero = dbz_q;
    assign md.hi          = hi_q;
    assign md.lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: vector table plus hand-written
// sequences for ignored start, back-to-back issue and mid-operation reset.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mult_div_unit_if #(.WIDTH(32)) md_if ();

    mult_div_unit #(
        .WIDTH(32),
        .CNT_W(6)
    ) dut (
        .clk(clk),
        .rst(rst),
        .md (md_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        md_op_e      op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start_op(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
        md_if.md_op = op;
        md_if.src_a = a;
        md_if.src_b = b;
        md_if.start = 1'b1;
        @(posedge clk);
        #1;
        md_if.start = 1'b0;
    endtask

    // Samples at each negedge after the accepting edge; lat = posedges from accept to done.
    task automatic wait_done(input int poke_at, output int lat, output int bc,
                             output logic dz_first, output logic to);
        lat      = 0;
        bc       = 0;
        dz_first = 1'b0;
        to       = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (k == 1) dz_first = md_if.div_by_zero;
            if (poke_at != 0 && k == poke_at) begin
                md_if.md_op = MD_DIV;
                md_if.src_a = 32'd100;
                md_if.src_b = 32'd7;
                md_if.start = 1'b1;
            end
            if (poke_at != 0 && k == poke_at + 1) md_if.start = 1'b0;
            if (md_if.busy) bc++;
            if (md_if.done) begin
                lat = k - 1;
                to  = 1'b0;
                break;
            end
        end
    endtask

    vec_t vecs[14];
    int   lat, bc, dones, busys;
    logic dz_first, to;

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        md_if.start = 1'b0;
        md_if.md_op = MD_MULT;
        md_if.src_a = '0;
        md_if.src_b = '0;

        vecs[0]  = '{MD_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[1]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[2]  = '{MD_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
        vecs[3]  = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[4]  = '{MD_DIVU,  32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC, 1'b0};
        vecs[5]  = '{MD_DIV,   32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1};
        vecs[6]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[7]  = '{MD_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1'b1};
        vecs[8]  = '{MD_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
        vecs[9]  = '{MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[10] = '{MD_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002, 1'b0};
        vecs[11] = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[12] = '{MD_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
        vecs[13] = '{MD_DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst busy", 64'(md_if.busy), 64'd0);
        check("rst done", 64'(md_if.done), 64'd0);
        check("rst dbz", 64'(md_if.div_by_zero), 64'd0);
        check("rst hi", 64'(md_if.hi), 64'd0);
        check("rst lo", 64'(md_if.lo), 64'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            start_op(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(0, lat, bc, dz_first, to);
            check($sformatf("v%0d timeout", i), 64'(to), 64'd0);
            check($sformatf("v%0d latency", i), 64'(lat), 64'd34);
            check($sformatf("v%0d busy cycles", i), 64'(bc), 64'd34);
            check($sformatf("v%0d dbz cleared on start", i), 64'(dz_first), 64'd0);
            check($sformatf("v%0d hi", i), 64'(md_if.hi), 64'(vecs[i].hi));
            check($sformatf("v%0d lo", i), 64'(md_if.lo), 64'(vecs[i].lo));
            check($sformatf("v%0d dbz", i), 64'(md_if.div_by_zero), 64'(vecs[i].dbz));
        end

        // Start pulsed mid-operation must be ignored
        @(negedge clk);
        start_op(MD_MULT, 32'd2, 32'd3);
        wait_done(10, lat, bc, dz_first, to);
        check("ign timeout", 64'(to), 64'd0);
        check("ign latency", 64'(lat), 64'd34);
        check("ign hi", 64'(md_if.hi), 64'd0);
        check("ign lo", 64'(md_if.lo), 64'd6);
        @(negedge clk);
        check("done one-cycle pulse", 64'(md_if.done), 64'd0);
        check("idle after done", 64'(md_if.busy), 64'd0);

        // Back-to-back issue on the done cycle
        @(negedge clk);
        start_op(MD_MULTU, 32'd2, 32'd3);
        wait_done(0, lat, bc, dz_first, to);
        check("b2b first lo", 64'(md_if.lo), 64'd6);
        start_op(MD_MULTU, 32'd5, 32'd6);
        wait_done(0, lat, bc, dz_first, to);
        check("b2b timeout", 64'(to), 64'd0);
        check("b2b latency", 64'(lat), 64'd34);
        check("b2b busy cycles", 64'(bc), 64'd34);
        check("b2b lo", 64'(md_if.lo), 64'd30);

        // Reset during a divide, with start asserted alongside reset
        @(negedge clk);
        start_op(MD_DIV, 32'd100, 32'd7);
        repeat (15) @(negedge clk);
        rst = 1'b1;
        md_if.md_op = MD_MULTU;
        md_if.src_a = 32'd9;
        md_if.src_b = 32'd9;
        md_if.start = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        md_if.start = 1'b0;
        @(negedge clk);
        check("abort busy", 64'(md_if.busy), 64'd0);
        check("abort hi", 64'(md_if.hi), 64'd0);
        check("abort lo", 64'(md_if.lo), 64'd0);
        check("abort done", 64'(md_if.done), 64'd0);
        dones = 0;
        busys = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (md_if.done) dones++;
            if (md_if.busy) busys++;
        end
        check("abort no done pulse", 64'(dones), 64'd0);
        check("start with rst ignored", 64'(busys), 64'd0);

        // Unit operates normally after the abort
        @(negedge clk);
        start_op(MD_MULTU, 32'd3, 32'd4);
        wait_done(0, lat, bc, dz_first, to);
        check("post-rst latency", 64'(lat), 64'd34);
        check("post-rst lo", 64'(md_if.lo), 64'd12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
